// File: rtl/mips_regfile_mp.sv
// mips_regfile_mp: parametrised multi-port MIPS register file.
//
// Sits between decode (operand reads, destination reservation) and the writeback ports.
// Provides deterministic write priority (highest port index wins), optional same-cycle
// write-to-read bypass, and a per-register busy scoreboard.
//
// Ports:
//   clk          clock, all state updates on the rising edge
//   rst_n        asynchronous active-low reset: clears registers, scoreboard and conflict flag
//   rd_addr      NUM_RD packed read addresses (port i at [i*ADDR_W +: ADDR_W])
//   rd_data      NUM_RD packed read data, combinational (port i at [i*DATA_W +: DATA_W])
//   rd_busy      per read port: addressed register has a pending writer
//   wr_en        per write port enable
//   wr_addr      NUM_WR packed write addresses
//   wr_data      NUM_WR packed write data
//   rsv_en       reserve (mark busy) rsv_addr at the edge
//   rsv_addr     register to reserve
//   busy_vec     registered scoreboard state
//   wr_conflict  registered: two or more effective writes shared a register last cycle
module mips_regfile_mp #(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned NUM_REGS = 32,
  parameter int unsigned ADDR_W   = 5,
  parameter int unsigned NUM_RD   = 2,
  parameter int unsigned NUM_WR   = 2,
  parameter int unsigned BYPASS   = 1,
  parameter int unsigned ZERO_REG = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_RD-1:0]        rd_busy,
  input  logic [NUM_WR-1:0]        wr_en,
  input  logic [NUM_WR*ADDR_W-1:0] wr_addr,
  input  logic [NUM_WR*DATA_W-1:0] wr_data,
  input  logic                     rsv_en,
  input  logic [ADDR_W-1:0]        rsv_addr,
  output logic [NUM_REGS-1:0]      busy_vec,
  output logic                     wr_conflict
);

  logic [DATA_W-1:0]   regs_q [NUM_REGS];
  logic [DATA_W-1:0]   regs_d [NUM_REGS];
  logic [NUM_REGS-1:0] busy_q, busy_d;
  logic                wr_conflict_q, wr_conflict_d;

  // Per-register resolved write: enable and the data of the winning port.
  logic [NUM_REGS-1:0] reg_we;
  logic [DATA_W-1:0]   reg_wdata [NUM_REGS];
  logic [NUM_WR-1:0]   wr_eff;
  logic                rsv_eff;

  function automatic logic addr_valid(input logic [ADDR_W-1:0] a);
    logic in_range;
    in_range   = (32'(a) < NUM_REGS);
    addr_valid = in_range && !((ZERO_REG != 0) && (a == '0));
  endfunction

  always_comb begin
    wr_eff = '0;
    for (int j = 0; j < int'(NUM_WR); j++) begin
      wr_eff[j] = wr_en[j] && addr_valid(wr_addr[j*ADDR_W +: ADDR_W]);
    end
    rsv_eff = rsv_en && addr_valid(rsv_addr);
  end

  // Ascending port scan: a later match overwrites, so the highest index wins.
  always_comb begin
    reg_we = '0;
    for (int r = 0; r < int'(NUM_REGS); r++) begin
      reg_wdata[r] = '0;
      for (int j = 0; j < int'(NUM_WR); j++) begin
        if (wr_eff[j] && (wr_addr[j*ADDR_W +: ADDR_W] == ADDR_W'(r))) begin
          reg_we[r]    = 1'b1;
          reg_wdata[r] = wr_data[j*DATA_W +: DATA_W];
        end
      end
    end
  end

  always_comb begin
    wr_conflict_d = 1'b0;
    for (int j = 0; j < int'(NUM_WR); j++) begin
      for (int k = j + 1; k < int'(NUM_WR); k++) begin
        if (wr_eff[j] && wr_eff[k] &&
            (wr_addr[j*ADDR_W +: ADDR_W] == wr_addr[k*ADDR_W +: ADDR_W])) begin
          wr_conflict_d = 1'b1;
        end
      end
    end
  end

  // Read ports: invalid -> 0; bypass hit -> winning write data, never busy; else stored.
  always_comb begin
    rd_data = '0;
    rd_busy = '0;
    for (int i = 0; i < int'(NUM_RD); i++) begin
      if (addr_valid(rd_addr[i*ADDR_W +: ADDR_W])) begin
        if ((BYPASS != 0) && reg_we[rd_addr[i*ADDR_W +: ADDR_W]]) begin
          rd_data[i*DATA_W +: DATA_W] = reg_wdata[rd_addr[i*ADDR_W +: ADDR_W]];
          rd_busy[i]                  = 1'b0;
        end else begin
          rd_data[i*DATA_W +: DATA_W] = regs_q[rd_addr[i*ADDR_W +: ADDR_W]];
          rd_busy[i]                  = busy_q[rd_addr[i*ADDR_W +: ADDR_W]];
        end
      end
    end
  end

  // Reserve beats a same-cycle write: it announces a newer in-flight producer.
  always_comb begin
    busy_d = busy_q;
    for (int r = 0; r < int'(NUM_REGS); r++) begin
      regs_d[r] = reg_we[r] ? reg_wdata[r] : regs_q[r];
      if (rsv_eff && (rsv_addr == ADDR_W'(r))) begin
        busy_d[r] = 1'b1;
      end else if (reg_we[r]) begin
        busy_d[r] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < int'(NUM_REGS); r++) begin
        regs_q[r] <= '0;
      end
      busy_q        <= '0;
      wr_conflict_q <= 1'b0;
    end else begin
      for (int r = 0; r < int'(NUM_REGS); r++) begin
        regs_q[r] <= regs_d[r];
      end
      busy_q        <= busy_d;
      wr_conflict_q <= wr_conflict_d;
    end
  end

  assign busy_vec    = busy_q;
  assign wr_conflict = wr_conflict_q;

endmodule

// File: tb/tb_mips_regfile_mp.sv
// Bench for mips_regfile_mp. Instance a: default 32x32, 2R/2W, bypass on.
// Instance b: 24 registers, 4R/3W, 64-bit, bypass off, checked against a random-stimulus model.
module tb_mips_regfile_mp;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [9:0]   a_rd_addr;
  logic [63:0]  a_rd_data;
  logic [1:0]   a_rd_busy;
  logic [1:0]   a_wr_en;
  logic [9:0]   a_wr_addr;
  logic [63:0]  a_wr_data;
  logic         a_rsv_en;
  logic [4:0]   a_rsv_addr;
  logic [31:0]  a_busy_vec;
  logic         a_wr_conflict;

  logic [19:0]  b_rd_addr;
  logic [255:0] b_rd_data;
  logic [3:0]   b_rd_busy;
  logic [2:0]   b_wr_en;
  logic [14:0]  b_wr_addr;
  logic [191:0] b_wr_data;
  logic         b_rsv_en;
  logic [4:0]   b_rsv_addr;
  logic [23:0]  b_busy_vec;
  logic         b_wr_conflict;

  int n_cmp = 0;
  int n_err = 0;

  mips_regfile_mp dut_a (
    .clk(clk), .rst_n(rst_n),
    .rd_addr(a_rd_addr), .rd_data(a_rd_data), .rd_busy(a_rd_busy),
    .wr_en(a_wr_en), .wr_addr(a_wr_addr), .wr_data(a_wr_data),
    .rsv_en(a_rsv_en), .rsv_addr(a_rsv_addr),
    .busy_vec(a_busy_vec), .wr_conflict(a_wr_conflict)
  );

  mips_regfile_mp #(
    .DATA_W(64), .NUM_REGS(24), .ADDR_W(5), .NUM_RD(4), .NUM_WR(3), .BYPASS(0), .ZERO_REG(1)
  ) dut_b (
    .clk(clk), .rst_n(rst_n),
    .rd_addr(b_rd_addr), .rd_data(b_rd_data), .rd_busy(b_rd_busy),
    .wr_en(b_wr_en), .wr_addr(b_wr_addr), .wr_data(b_wr_data),
    .rsv_en(b_rsv_en), .rsv_addr(b_rsv_addr),
    .busy_vec(b_busy_vec), .wr_conflict(b_wr_conflict)
  );

  task automatic idle();
    a_rd_addr = '0; a_wr_en = '0; a_wr_addr = '0; a_wr_data = '0; a_rsv_en = 1'b0;
    a_rsv_addr = '0;
    b_rd_addr = '0; b_wr_en = '0; b_wr_addr = '0; b_wr_data = '0; b_rsv_en = 1'b0;
    b_rsv_addr = '0;
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle();
    #2;
    n_cmp++;
    if (a_busy_vec !== 32'h0 || a_wr_conflict !== 1'b0 || a_rd_data !== 64'h0) begin
      n_err++;
      $display("FAIL reset_init: busy=%h conf=%b rd=%h want 0", a_busy_vec, a_wr_conflict,
               a_rd_data);
    end
    step();
    rst_n = 1'b1;
    a_wr_en = 2'b11;
    a_wr_addr = {5'd5, 5'd5};
    a_wr_data = {32'hDEADBEEF, 32'hDEADBEEF};
    a_rsv_en = 1'b1;
    a_rsv_addr = 5'd6;
    step();
    idle();
    a_rd_addr = {5'd6, 5'd5};
    #3;
    n_cmp++;
    if (a_rd_data[31:0] !== 32'hDEADBEEF || a_busy_vec[6] !== 1'b1 || a_wr_conflict !== 1'b1)
    begin
      n_err++;
      $display("FAIL reset_prefill: rd=%h busy6=%b conf=%b want deadbeef 1 1",
               a_rd_data[31:0], a_busy_vec[6], a_wr_conflict);
    end
    // Reset mid-cycle with a write and reserve in flight.
    rst_n = 1'b0;
    a_wr_en = 2'b01;
    a_wr_addr = {5'd0, 5'd10};
    a_wr_data = {32'h0, 32'h12345678};
    a_rsv_en = 1'b1;
    a_rsv_addr = 5'd8;
    #1;
    n_cmp++;
    if (a_rd_data[31:0] !== 32'h0 || a_busy_vec !== 32'h0 || a_wr_conflict !== 1'b0) begin
      n_err++;
      $display("FAIL reset_async: rd=%h busy=%h conf=%b want 0 0 0", a_rd_data[31:0],
               a_busy_vec, a_wr_conflict);
    end
    step();
    idle();
    a_rd_addr = {5'd8, 5'd10};
    #1;
    n_cmp++;
    if (a_rd_data !== 64'h0 || a_busy_vec !== 32'h0) begin
      n_err++;
      $display("FAIL reset_edge_lost: rd=%h busy=%h want 0 0", a_rd_data, a_busy_vec);
    end
    #1;
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_priority();
    a_wr_en = 2'b11;
    a_wr_addr = {5'd7, 5'd7};
    a_wr_data = {32'h2222, 32'h1111};
    a_rd_addr = {5'd7, 5'd7};
    #3;
    n_cmp++;
    if (a_rd_data !== {32'h2222, 32'h2222}) begin
      n_err++;
      $display("FAIL prio_bypass: got %h want 0000222200002222", a_rd_data);
    end
    step();
    idle();
    a_rd_addr = {5'd7, 5'd7};
    #3;
    n_cmp++;
    if (a_rd_data[31:0] !== 32'h2222 || a_wr_conflict !== 1'b1) begin
      n_err++;
      $display("FAIL prio_stored: rd=%h conf=%b want 2222 1", a_rd_data[31:0], a_wr_conflict);
    end
    step();
    n_cmp++;
    if (a_wr_conflict !== 1'b0) begin
      n_err++;
      $display("FAIL prio_conf_clear: got %b want 0", a_wr_conflict);
    end
  endtask

  task automatic test_zero_range();
    a_wr_en = 2'b11;
    a_wr_addr = {5'd0, 5'd0};
    a_wr_data = {32'h1234, 32'hFFFF};
    a_rsv_en = 1'b1;
    a_rsv_addr = 5'd0;
    a_rd_addr = {5'd7, 5'd0};
    b_wr_en = 3'b111;
    b_wr_addr = {5'd24, 5'd0, 5'd30};
    b_wr_data = {64'h3, 64'h2, 64'hFFFF};
    b_rsv_en = 1'b1;
    b_rsv_addr = 5'd30;
    b_rd_addr = {5'd3, 5'd24, 5'd0, 5'd30};
    #3;
    n_cmp++;
    if (a_rd_data[31:0] !== 32'h0 || a_rd_busy !== 2'b00 || b_rd_data !== 256'h0) begin
      n_err++;
      $display("FAIL zero_same_cycle: a_rd=%h a_busy=%b b_rd=%h want 0", a_rd_data[31:0],
               a_rd_busy, b_rd_data);
    end
    step();
    idle();
    a_rd_addr = {5'd7, 5'd0};
    b_rd_addr = {5'd3, 5'd24, 5'd0, 5'd30};
    #3;
    n_cmp++;
    if (a_rd_data !== {32'h2222, 32'h0} || a_busy_vec !== 32'h0 || a_wr_conflict !== 1'b0) begin
      n_err++;
      $display("FAIL zero_after_a: rd=%h busy=%h conf=%b want 0000222200000000 0 0", a_rd_data,
               a_busy_vec, a_wr_conflict);
    end
    n_cmp++;
    if (b_rd_data !== 256'h0 || b_busy_vec !== 24'h0 || b_wr_conflict !== 1'b0) begin
      n_err++;
      $display("FAIL range_after_b: rd=%h busy=%h conf=%b want 0", b_rd_data, b_busy_vec,
               b_wr_conflict);
    end
    step();
  endtask

  task automatic test_bypass();
    a_wr_en = 2'b01; a_wr_addr = {5'd0, 5'd3}; a_wr_data = {32'h0, 32'hA};
    b_wr_en = 3'b001; b_wr_addr = {10'd0, 5'd3}; b_wr_data = {128'h0, 64'hA};
    step();
    a_wr_data = {32'h0, 32'hB};
    b_wr_data = {128'h0, 64'hB};
    a_rd_addr = {5'd0, 5'd3};
    b_rd_addr = {15'd0, 5'd3};
    #3;
    n_cmp++;
    if (a_rd_data[31:0] !== 32'hB) begin
      n_err++;
      $display("FAIL bypass_on_same: got %h want b", a_rd_data[31:0]);
    end
    n_cmp++;
    if (b_rd_data[63:0] !== 64'hA) begin
      n_err++;
      $display("FAIL bypass_off_same: got %h want a", b_rd_data[63:0]);
    end
    step();
    idle();
    a_rd_addr = {5'd0, 5'd3};
    b_rd_addr = {15'd0, 5'd3};
    #3;
    n_cmp++;
    if (a_rd_data[31:0] !== 32'hB || b_rd_data[63:0] !== 64'hB) begin
      n_err++;
      $display("FAIL bypass_next: a=%h b=%h want b b", a_rd_data[31:0], b_rd_data[63:0]);
    end
    step();
  endtask

  task automatic test_scoreboard();
    a_rsv_en = 1'b1; a_rsv_addr = 5'd9; a_rd_addr = {5'd0, 5'd9};
    #3;
    n_cmp++;
    if (a_rd_busy[0] !== 1'b0) begin
      n_err++;
      $display("FAIL sb_not_yet: got %b want 0", a_rd_busy[0]);
    end
    step();
    idle();
    a_rd_addr = {5'd0, 5'd9};
    #3;
    n_cmp++;
    if (a_busy_vec !== 32'h200 || a_rd_busy[0] !== 1'b1) begin
      n_err++;
      $display("FAIL sb_reserved: busy=%h rd_busy=%b want 00000200 1", a_busy_vec, a_rd_busy[0]);
    end
    step();
    a_wr_en = 2'b01; a_wr_addr = {5'd0, 5'd9}; a_wr_data = {32'h0, 32'h99};
    a_rsv_en = 1'b1; a_rsv_addr = 5'd9;
    #3;
    n_cmp++;
    if (a_rd_busy[0] !== 1'b0 || a_rd_data[31:0] !== 32'h99) begin
      n_err++;
      $display("FAIL sb_wr_rsv_bypass: busy=%b rd=%h want 0 99", a_rd_busy[0], a_rd_data[31:0]);
    end
    step();
    idle();
    a_rd_addr = {5'd0, 5'd9};
    #3;
    n_cmp++;
    if (a_busy_vec[9] !== 1'b1 || a_rd_busy[0] !== 1'b1) begin
      n_err++;
      $display("FAIL sb_rsv_wins: busy9=%b rd_busy=%b want 1 1", a_busy_vec[9], a_rd_busy[0]);
    end
    step();
    a_wr_en = 2'b10; a_wr_addr = {5'd9, 5'd0}; a_wr_data = {32'h77, 32'h0};
    #3;
    n_cmp++;
    if (a_rd_busy[0] !== 1'b0 || a_rd_data[31:0] !== 32'h77) begin
      n_err++;
      $display("FAIL sb_write_bypass: busy=%b rd=%h want 0 77", a_rd_busy[0], a_rd_data[31:0]);
    end
    step();
    idle();
    a_rd_addr = {5'd0, 5'd9};
    #3;
    n_cmp++;
    if (a_busy_vec !== 32'h0 || a_rd_busy[0] !== 1'b0) begin
      n_err++;
      $display("FAIL sb_cleared: busy=%h rd_busy=%b want 0 0", a_busy_vec, a_rd_busy[0]);
    end
    step();
  endtask

  // Biased towards a small window so port collisions and read-after-write hits are common.
  function automatic logic [4:0] rand_addr();
    if ($urandom_range(0, 3) == 0) return 5'($urandom_range(0, 31));
    return 5'($urandom_range(0, 7));
  endfunction

  function automatic bit m_valid(input logic [4:0] a);
    return (a < 5'd24) && (a != 5'd0);
  endfunction

  task automatic test_random();
    logic [63:0] m_mem [24];
    logic [23:0] m_busy;
    logic        m_conf;
    int          cnt [24];
    logic [4:0]  a;
    logic [63:0] exp_d;
    logic        exp_b;
    rst_n = 1'b0;
    idle();
    #2;
    rst_n = 1'b1;
    for (int r = 0; r < 24; r++) m_mem[r] = '0;
    m_busy = '0;
    m_conf = 1'b0;
    step();
    for (int c = 0; c < 5000; c++) begin
      for (int j = 0; j < 3; j++) begin
        b_wr_en[j] = 1'($urandom_range(0, 1));
        b_wr_addr[j*5 +: 5] = rand_addr();
        b_wr_data[j*64 +: 64] = {$urandom, $urandom};
      end
      b_rsv_en = 1'($urandom_range(0, 1));
      b_rsv_addr = rand_addr();
      for (int i = 0; i < 4; i++) b_rd_addr[i*5 +: 5] = rand_addr();
      #3;
      for (int i = 0; i < 4; i++) begin
        a = b_rd_addr[i*5 +: 5];
        exp_d = m_valid(a) ? m_mem[a] : 64'h0;
        exp_b = m_valid(a) ? m_busy[a] : 1'b0;
        n_cmp++;
        if (b_rd_data[i*64 +: 64] !== exp_d) begin
          n_err++;
          $display("FAIL rand_rd_data c%0d p%0d a%0d: got %h want %h", c, i, a,
                   b_rd_data[i*64 +: 64], exp_d);
        end
        n_cmp++;
        if (b_rd_busy[i] !== exp_b) begin
          n_err++;
          $display("FAIL rand_rd_busy c%0d p%0d a%0d: got %b want %b", c, i, a, b_rd_busy[i],
                   exp_b);
        end
      end
      n_cmp++;
      if (b_busy_vec !== m_busy) begin
        n_err++;
        $display("FAIL rand_busy_vec c%0d: got %h want %h", c, b_busy_vec, m_busy);
      end
      n_cmp++;
      if (b_wr_conflict !== m_conf) begin
        n_err++;
        $display("FAIL rand_conflict c%0d: got %b want %b", c, b_wr_conflict, m_conf);
      end
      // Model update: ports applied in ascending order, so the highest index lands last.
      for (int r = 0; r < 24; r++) cnt[r] = 0;
      for (int j = 0; j < 3; j++) begin
        a = b_wr_addr[j*5 +: 5];
        if (b_wr_en[j] && m_valid(a)) begin
          m_mem[a] = b_wr_data[j*64 +: 64];
          cnt[a]++;
        end
      end
      m_conf = 1'b0;
      for (int r = 0; r < 24; r++) begin
        if (cnt[r] >= 2) m_conf = 1'b1;
        if (b_rsv_en && m_valid(b_rsv_addr) && (int'(b_rsv_addr) == r)) m_busy[r] = 1'b1;
        else if (cnt[r] > 0) m_busy[r] = 1'b0;
      end
      step();
    end
    idle();
  endtask

  initial begin
    test_reset();
    test_priority();
    test_zero_range();
    test_bypass();
    test_scoreboard();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
